// File: rtl/mem_stage_pkg.sv
// Shared types for the MEM stage: FSM states, store size codes, load-select layout.
// MEM_UNALIGNED_LS_EN keeps the LWL/LWR load-select bits; otherwise they are cleared.
package mem_stage_pkg;

  localparam int GPR_W      = 5;
  localparam int LOAD_SEL_W = 11;

  // Load-select layout: [4:0] LB/LBU/LH/LHU/LW, [7:5] L0-L2, [10:8] R1-R3.
  // A size-3 store is SWL when any L bit is set, otherwise SWR.
  localparam logic [LOAD_SEL_W-1:0] LSEL_L_MASK = 11'b000_1110_0000;
  localparam logic [LOAD_SEL_W-1:0] LSEL_R_MASK = 11'b111_0000_0000;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;
  localparam logic [1:0] SIZE_UNAL = 2'd3;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_REQ   = 2'd1,
    ST_DONE  = 2'd2
  } mem_state_e;

  typedef enum logic [2:0] {
    SK_NONE = 3'd0,
    SK_B    = 3'd1,
    SK_H    = 3'd2,
    SK_W    = 3'd3,
    SK_L    = 3'd4,
    SK_R    = 3'd5
  } store_kind_e;

  function automatic logic [LOAD_SEL_W-1:0] keep_load_sel(input logic [LOAD_SEL_W-1:0] sel);
`ifdef MEM_UNALIGNED_LS_EN
    keep_load_sel = sel;
`else
    keep_load_sel = sel & ~(LSEL_L_MASK | LSEL_R_MASK);
`endif
  endfunction

endpackage

// File: rtl/mem_stage_store_align.sv
// Combinational store strobe/data alignment for byte, half, word and (MEM_UNALIGNED_LS_EN) SWL/SWR.
// Zero latency; no flow control of its own.
module mem_stage_store_align
  import mem_stage_pkg::*;
(
  input  store_kind_e kind,
  input  logic [1:0]  off,
  input  logic [31:0] rt,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata
);

  always_comb begin
    wstrb = 4'b0000;
    wdata = 32'h0;
    case (kind)
      SK_B: begin
        wstrb = 4'b0001 << off;
        wdata = {4{rt[7:0]}};
      end
      SK_H: begin
        wstrb = 4'b0011 << off;
        wdata = {2{rt[15:0]}};
      end
      SK_W: begin
        wstrb = 4'b1111;
        wdata = rt;
      end
`ifdef MEM_UNALIGNED_LS_EN
      SK_L: begin
        wstrb = 4'b1111 >> (2'd3 - off);
        wdata = rt >> (5'd24 - {off, 3'b000});
      end
      SK_R: begin
        wstrb = 4'b1111 << off;
        wdata = rt << {off, 3'b000};
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: one data-bus address request per load/store, result held for WB until taken.
// Stalls EXE while the request is pending or WB refuses; MEM_UNALIGNED_LS_EN enables SWL/SWR.
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  EXE_valid_w_i,
  output logic                  MEM_allowin_w_o,
  input  logic                  WB_allowin_w_i,
  output logic                  MEM_valid_w_o,
  input  logic                  flush_w_i,
  input  logic                  EXE_memReq_i,
  input  logic                  EXE_memWrite_i,
  input  logic [1:0]            EXE_memSize_i,
  input  logic [31:0]           EXE_memAddr_i,
  input  logic [31:0]           EXE_rtData_i,
  input  logic [31:0]           EXE_VAddr_i,
  input  logic [31:0]           EXE_finalRes_i,
  input  logic [GPR_W-1:0]      EXE_writeNum_i,
  input  logic [LOAD_SEL_W-1:0] EXE_loadSel_i,
  input  logic                  EXE_exceptionRisk_i,
  input  logic                  EXE_isDangerous_i,
  output logic [GPR_W-1:0]      MEM_writeNum_i,
  output logic [31:0]           MEM_finalRes_i,
  output logic [31:0]           MEM_VAddr_i,
  output logic [31:0]           MEM_rtData_i,
  output logic                  MEM_exceptionRisk_i,
  output logic                  MEM_isDangerous_i,
  output logic [LOAD_SEL_W-1:0] MEM_loadSel_i,
  output logic [1:0]            MEM_alignCheck_i,
  output logic                  data_req,
  output logic                  data_wr,
  output logic [1:0]            data_size,
  output logic [31:0]           data_addr,
  output logic [31:0]           data_wdata,
  output logic [3:0]            data_wstrb,
  input  logic                  data_addr_ok
);

  mem_state_e  state;
  store_kind_e kind_q;
  store_kind_e exe_kind;
  logic [31:2] addr_q;
  logic        wr_q;
  logic        accept;
  logic        needs_bus;

  assign MEM_allowin_w_o = (state == ST_EMPTY) || (state == ST_DONE && WB_allowin_w_i);
  assign MEM_valid_w_o   = (state == ST_DONE);
  assign accept          = EXE_valid_w_i && MEM_allowin_w_o && !flush_w_i;

  always_comb begin
    exe_kind = SK_NONE;
    if (EXE_memWrite_i) begin
      case (EXE_memSize_i)
        SIZE_BYTE: exe_kind = SK_B;
        SIZE_HALF: exe_kind = SK_H;
        SIZE_WORD: exe_kind = SK_W;
`ifdef MEM_UNALIGNED_LS_EN
        SIZE_UNAL: exe_kind = (|(EXE_loadSel_i & LSEL_L_MASK)) ? SK_L : SK_R;
`else
        SIZE_UNAL: exe_kind = SK_NONE;
`endif
      endcase
    end
    // A store with no usable kind (disabled SWL/SWR) completes without touching the bus.
    needs_bus = EXE_memReq_i && !EXE_exceptionRisk_i && !(EXE_memWrite_i && exe_kind == SK_NONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state               <= ST_EMPTY;
      kind_q              <= SK_NONE;
      addr_q              <= '0;
      wr_q                <= 1'b0;
      MEM_writeNum_i      <= '0;
      MEM_finalRes_i      <= '0;
      MEM_VAddr_i         <= '0;
      MEM_rtData_i        <= '0;
      MEM_exceptionRisk_i <= 1'b0;
      MEM_isDangerous_i   <= 1'b0;
      MEM_loadSel_i       <= '0;
      MEM_alignCheck_i    <= '0;
    end else begin
      if (accept) begin
        kind_q              <= exe_kind;
        addr_q              <= EXE_memAddr_i[31:2];
        wr_q                <= EXE_memWrite_i;
        MEM_writeNum_i      <= EXE_writeNum_i;
        MEM_finalRes_i      <= EXE_finalRes_i;
        MEM_VAddr_i         <= EXE_VAddr_i;
        MEM_rtData_i        <= EXE_rtData_i;
        MEM_exceptionRisk_i <= EXE_exceptionRisk_i;
        MEM_isDangerous_i   <= EXE_isDangerous_i;
        MEM_loadSel_i       <= keep_load_sel(EXE_loadSel_i);
        MEM_alignCheck_i    <= EXE_memAddr_i[1:0];
      end
      if (flush_w_i) begin
        state <= ST_EMPTY;
      end else begin
        case (state)
          ST_REQ: if (data_addr_ok) state <= ST_DONE;
          ST_EMPTY, ST_DONE: begin
            if (accept)
              state <= needs_bus ? ST_REQ : ST_DONE;
            else if (state == ST_DONE && WB_allowin_w_i)
              state <= ST_EMPTY;
          end
          default: state <= ST_EMPTY;
        endcase
      end
    end
  end

  assign data_req  = (state == ST_REQ);
  assign data_wr   = wr_q;
  assign data_addr = {addr_q, 2'b00};

  always_comb begin
    data_size = SIZE_WORD;
    if (kind_q == SK_B)      data_size = SIZE_BYTE;
    else if (kind_q == SK_H) data_size = SIZE_HALF;
  end

  mem_stage_store_align store_align (
    .kind  (kind_q),
    .off   (MEM_alignCheck_i),
    .rt    (MEM_rtData_i),
    .wstrb (data_wstrb),
    .wdata (data_wdata)
  );

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: literal directed sequences, then randomized traffic against a slot-level model.
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic clk, rst;
  logic EXE_valid_w_i, MEM_allowin_w_o, WB_allowin_w_i, MEM_valid_w_o, flush_w_i;
  logic EXE_memReq_i, EXE_memWrite_i;
  logic [1:0] EXE_memSize_i;
  logic [31:0] EXE_memAddr_i, EXE_rtData_i, EXE_VAddr_i, EXE_finalRes_i;
  logic [GPR_W-1:0] EXE_writeNum_i, MEM_writeNum_i;
  logic [LOAD_SEL_W-1:0] EXE_loadSel_i, MEM_loadSel_i;
  logic EXE_exceptionRisk_i, EXE_isDangerous_i;
  logic [31:0] MEM_finalRes_i, MEM_VAddr_i, MEM_rtData_i;
  logic MEM_exceptionRisk_i, MEM_isDangerous_i;
  logic [1:0] MEM_alignCheck_i;
  logic data_req, data_wr, data_addr_ok;
  logic [1:0] data_size;
  logic [31:0] data_addr, data_wdata;
  logic [3:0] data_wstrb;

  int total = 0;
  int bad = 0;

  mem_stage dut (
    .clk(clk), .rst(rst),
    .EXE_valid_w_i(EXE_valid_w_i), .MEM_allowin_w_o(MEM_allowin_w_o),
    .WB_allowin_w_i(WB_allowin_w_i), .MEM_valid_w_o(MEM_valid_w_o), .flush_w_i(flush_w_i),
    .EXE_memReq_i(EXE_memReq_i), .EXE_memWrite_i(EXE_memWrite_i), .EXE_memSize_i(EXE_memSize_i),
    .EXE_memAddr_i(EXE_memAddr_i), .EXE_rtData_i(EXE_rtData_i), .EXE_VAddr_i(EXE_VAddr_i),
    .EXE_finalRes_i(EXE_finalRes_i), .EXE_writeNum_i(EXE_writeNum_i), .EXE_loadSel_i(EXE_loadSel_i),
    .EXE_exceptionRisk_i(EXE_exceptionRisk_i), .EXE_isDangerous_i(EXE_isDangerous_i),
    .MEM_writeNum_i(MEM_writeNum_i), .MEM_finalRes_i(MEM_finalRes_i), .MEM_VAddr_i(MEM_VAddr_i),
    .MEM_rtData_i(MEM_rtData_i), .MEM_exceptionRisk_i(MEM_exceptionRisk_i),
    .MEM_isDangerous_i(MEM_isDangerous_i), .MEM_loadSel_i(MEM_loadSel_i),
    .MEM_alignCheck_i(MEM_alignCheck_i),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_wstrb(data_wstrb), .data_addr_ok(data_addr_ok)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic exe(input logic v, input logic rq, input logic w, input logic [1:0] sz,
                     input logic [31:0] a, input logic [31:0] rtd, input logic [31:0] fr,
                     input logic [LOAD_SEL_W-1:0] sel);
    EXE_valid_w_i = v;  EXE_memReq_i = rq; EXE_memWrite_i = w; EXE_memSize_i = sz;
    EXE_memAddr_i = a;  EXE_rtData_i = rtd; EXE_finalRes_i = fr; EXE_VAddr_i = fr + 32'h4;
    EXE_writeNum_i = fr[GPR_W-1:0]; EXE_loadSel_i = sel;
    EXE_exceptionRisk_i = 1'b0; EXE_isDangerous_i = 1'b0;
  endtask

  // Expected store lanes from byte arithmetic: kind 1 SB, 2 SH, 3 SW, 4 SWL, 5 SWR.
  function automatic void exp_store(input int k, input logic [31:0] a, input logic [31:0] rt,
                                    output logic [3:0] st, output logic [31:0] wd);
    int o;
    o = int'(a[1:0]);
    st = 4'b0000;
    wd = 32'h0;
    case (k)
      1: begin st[o] = 1'b1; wd = {24'h0, rt[7:0]} * 32'h0101_0101; end
      2: begin st[o] = 1'b1; if (o < 3) st[o+1] = 1'b1; wd = {16'h0, rt[15:0]} * 32'h0001_0001; end
      3: begin st = 4'b1111; wd = rt; end
      4: begin for (int b = 0; b <= o; b++) st[b] = 1'b1; wd = rt >> (8 * (3 - o)); end
      5: begin for (int b = o; b < 4; b++) st[b] = 1'b1; wd = rt << (8 * o); end
      default: ;
    endcase
  endfunction

  // Model: one instruction slot, occupied or not, with a bus request outstanding or not.
  logic m_occ, m_pend, m_wr, m_exc, m_dang;
  int m_kind;
  logic [31:0] m_addr, m_rt, m_fres, m_vaddr;
  logic [GPR_W-1:0] m_wnum;
  logic [LOAD_SEL_W-1:0] m_lsel;

  initial begin
    logic [3:0] est;
    logic [31:0] ewd;
    bit e_allow, e_req, acc, bus;
    int k, r;

    rst = 1'b0; flush_w_i = 1'b0; WB_allowin_w_i = 1'b1; data_addr_ok = 1'b0;
    exe(1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 32'h0, '0);
    #3;
    chk("reset_valid", MEM_valid_w_o, 0);
    chk("reset_req", data_req, 0);
    chk("reset_allowin", MEM_allowin_w_o, 1);
    chk("reset_finalres", MEM_finalRes_i, 0);
    chk("reset_loadsel", MEM_loadSel_i, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    // Four back-to-back ALU ops, one per cycle, no bus traffic.
    for (int i = 0; i < 4; i++) begin
      exe(1'b1, 1'b0, 1'b0, 2'd2, 32'h0, 32'h0, 32'h100 + i, '0);
      #1;
      chk("alu_allowin", MEM_allowin_w_o, 1);
      chk("alu_req", data_req, 0);
      step();
      chk("alu_valid", MEM_valid_w_o, 1);
      chk("alu_finalres", MEM_finalRes_i, 32'h100 + i);
      chk("alu_req_after", data_req, 0);
    end
    EXE_valid_w_i = 1'b0;
    step();
    chk("alu_drain", MEM_valid_w_o, 0);

    // SB to 0x1003.
    exe(1'b1, 1'b1, 1'b1, 2'd0, 32'h1003, 32'h0000_00AB, 32'h55, '0);
    step();
    EXE_valid_w_i = 1'b0;
    #1;
    chk("sb_req", data_req, 1);
    chk("sb_wstrb", data_wstrb, 4'b1000);
    chk("sb_wdata", data_wdata, 32'hABAB_ABAB);
    chk("sb_addr", data_addr, 32'h1000);
    chk("sb_size", data_size, 0);
    chk("sb_wr", data_wr, 1);
    chk("sb_align", MEM_alignCheck_i, 3);
    chk("sb_allowin", MEM_allowin_w_o, 0);
    data_addr_ok = 1'b1;
    step();
    data_addr_ok = 1'b0;
    chk("sb_valid", MEM_valid_w_o, 1);
    chk("sb_req_done", data_req, 0);
    step();

    // LW with the address handshake held off for three cycles.
    exe(1'b1, 1'b1, 1'b0, 2'd2, 32'h2002, 32'h0, 32'h66, 11'h010);
    step();
    EXE_valid_w_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("lw_stall_allowin", MEM_allowin_w_o, 0);
      chk("lw_stall_req", data_req, 1);
      chk("lw_stall_valid", MEM_valid_w_o, 0);
      step();
    end
    chk("lw_addr", data_addr, 32'h2000);
    chk("lw_size", data_size, 2);
    chk("lw_wr", data_wr, 0);
    data_addr_ok = 1'b1;
    #1 chk("lw_ok_allowin", MEM_allowin_w_o, 0);
    step();
    data_addr_ok = 1'b0;
    chk("lw_valid", MEM_valid_w_o, 1);
    chk("lw_loadsel", MEM_loadSel_i, 11'h010);

    // WB refuses for two cycles: everything holds, no new request.
    WB_allowin_w_i = 1'b0;
    exe(1'b1, 1'b0, 1'b0, 2'd2, 32'h0, 32'h0, 32'h777, '0);
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("wbhold_allowin", MEM_allowin_w_o, 0);
      chk("wbhold_valid", MEM_valid_w_o, 1);
      chk("wbhold_req", data_req, 0);
      chk("wbhold_finalres", MEM_finalRes_i, 32'h66);
      step();
    end
    WB_allowin_w_i = 1'b1;
    #1 chk("wbhold_release", MEM_allowin_w_o, 1);
    step();
    chk("wbhold_next", MEM_finalRes_i, 32'h777);
    EXE_valid_w_i = 1'b0;
    step();

    // SW, then flush on the same edge as addr_ok, with EXE offering an op.
    exe(1'b1, 1'b1, 1'b1, 2'd2, 32'h3000, 32'h1234_5678, 32'h33, '0);
    step();
    EXE_valid_w_i = 1'b0;
    #1;
    chk("sw_wstrb", data_wstrb, 4'b1111);
    chk("sw_wdata", data_wdata, 32'h1234_5678);
    flush_w_i = 1'b1; data_addr_ok = 1'b1;
    exe(1'b1, 1'b0, 1'b0, 2'd2, 32'h0, 32'h0, 32'h99, '0);
    #1 chk("flush_allowin", MEM_allowin_w_o, 0);
    step();
    flush_w_i = 1'b0; data_addr_ok = 1'b0; EXE_valid_w_i = 1'b0;
    #1;
    chk("flush_valid", MEM_valid_w_o, 0);
    chk("flush_allowin_after", MEM_allowin_w_o, 1);
    chk("flush_finalres", MEM_finalRes_i, 32'h33);
    chk("flush_req", data_req, 0);
    flush_w_i = 1'b1;
    exe(1'b1, 1'b0, 1'b0, 2'd2, 32'h0, 32'h0, 32'hAA, '0);
    step();
    flush_w_i = 1'b0; EXE_valid_w_i = 1'b0;
    #1;
    chk("flushexe_valid", MEM_valid_w_o, 0);
    chk("flushexe_finalres", MEM_finalRes_i, 32'h33);

    // SWL at offset 1.
    exe(1'b1, 1'b1, 1'b1, 2'd3, 32'h4001, 32'h1122_3344, 32'h44, 11'h020);
    step();
    EXE_valid_w_i = 1'b0;
    #1;
`ifdef MEM_UNALIGNED_LS_EN
    chk("swl_req", data_req, 1);
    chk("swl_wstrb", data_wstrb, 4'b0011);
    chk("swl_wdata", data_wdata, 32'h0000_1122);
    chk("swl_addr", data_addr, 32'h4000);
    data_addr_ok = 1'b1;
    step();
    data_addr_ok = 1'b0;
    chk("swl_valid", MEM_valid_w_o, 1);
    chk("swl_loadsel", MEM_loadSel_i, 11'h020);
`else
    chk("swl_off_req", data_req, 0);
    chk("swl_off_valid", MEM_valid_w_o, 1);
    chk("swl_off_wstrb", data_wstrb, 4'b0000);
    chk("swl_off_loadsel", MEM_loadSel_i, 0);
`endif
    step();

    // Asynchronous reset in the middle of a pending request.
    exe(1'b1, 1'b1, 1'b0, 2'd2, 32'h100, 32'h0, 32'h88, 11'h010);
    step();
    EXE_valid_w_i = 1'b0;
    #1;
    chk("rstreq_req", data_req, 1);
    chk("rstreq_addr", data_addr, 32'h100);
    #1 rst = 1'b0;
    #1;
    chk("rstreq_req_low", data_req, 0);
    chk("rstreq_valid", MEM_valid_w_o, 0);
    chk("rstreq_allowin", MEM_allowin_w_o, 1);
    chk("rstreq_finalres", MEM_finalRes_i, 0);
    @(posedge clk);
    #1 rst = 1'b1;

    // Randomized traffic against the slot model.
    m_occ = 0; m_pend = 0; m_wr = 0; m_exc = 0; m_dang = 0; m_kind = 0;
    m_addr = 0; m_rt = 0; m_fres = 0; m_vaddr = 0; m_wnum = '0; m_lsel = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      r = $urandom_range(0, 5);
      EXE_valid_w_i  = ($urandom_range(0, 9) < 7);
      EXE_memReq_i   = (r != 0);
      EXE_memWrite_i = (r >= 2) ? 1'b1 : (r == 0 ? 1'($urandom_range(0, 1)) : 1'b0);
      EXE_memSize_i  = (r >= 2) ? 2'(r - 2) : 2'($urandom_range(0, 3));
      EXE_memAddr_i  = $urandom;
      EXE_rtData_i   = $urandom;
      EXE_VAddr_i    = $urandom;
      EXE_finalRes_i = $urandom;
      EXE_writeNum_i = GPR_W'($urandom);
      EXE_loadSel_i  = LOAD_SEL_W'($urandom);
      EXE_exceptionRisk_i = ($urandom_range(0, 7) == 0);
      EXE_isDangerous_i   = 1'($urandom_range(0, 1));
      WB_allowin_w_i = ($urandom_range(0, 9) < 7);
      data_addr_ok   = ($urandom_range(0, 9) < 4);
      flush_w_i      = ($urandom_range(0, 19) == 0);
      #1;
      e_allow = !m_occ || (!m_pend && WB_allowin_w_i);
      e_req   = m_occ && m_pend;
      chk("rnd_allowin", MEM_allowin_w_o, e_allow);
      chk("rnd_valid", MEM_valid_w_o, m_occ && !m_pend);
      chk("rnd_req", data_req, e_req);
      chk("rnd_wnum", MEM_writeNum_i, m_wnum);
      chk("rnd_fres", MEM_finalRes_i, m_fres);
      chk("rnd_vaddr", MEM_VAddr_i, m_vaddr);
      chk("rnd_rt", MEM_rtData_i, m_rt);
      chk("rnd_exc", MEM_exceptionRisk_i, m_exc);
      chk("rnd_dang", MEM_isDangerous_i, m_dang);
      chk("rnd_lsel", MEM_loadSel_i, m_lsel);
      chk("rnd_align", MEM_alignCheck_i, m_addr % 4);
      if (e_req) begin
        exp_store(m_kind, m_addr, m_rt, est, ewd);
        chk("rnd_bus_wr", data_wr, m_wr);
        chk("rnd_bus_addr", data_addr, m_addr - (m_addr % 4));
        chk("rnd_bus_size", data_size, (m_kind == 1) ? 0 : (m_kind == 2) ? 1 : 2);
        chk("rnd_bus_wstrb", data_wstrb, est);
        chk("rnd_bus_wdata", data_wdata, ewd);
      end
      acc = EXE_valid_w_i && e_allow && !flush_w_i;
      k = 0;
      if (EXE_memWrite_i) begin
        if (EXE_memSize_i < 3) k = EXE_memSize_i + 1;
`ifdef MEM_UNALIGNED_LS_EN
        else k = (EXE_loadSel_i[7:5] != 0) ? 4 : 5;
`endif
      end
      bus = EXE_memReq_i && !EXE_exceptionRisk_i && !(EXE_memWrite_i && k == 0);
      if (acc) begin
        m_wr = EXE_memWrite_i; m_exc = EXE_exceptionRisk_i; m_dang = EXE_isDangerous_i;
        m_kind = k; m_addr = EXE_memAddr_i; m_rt = EXE_rtData_i; m_fres = EXE_finalRes_i;
        m_vaddr = EXE_VAddr_i; m_wnum = EXE_writeNum_i;
`ifdef MEM_UNALIGNED_LS_EN
        m_lsel = EXE_loadSel_i;
`else
        m_lsel = EXE_loadSel_i & 11'h01F;
`endif
      end
      if (flush_w_i) begin
        m_occ = 0; m_pend = 0;
      end else if (m_occ && m_pend) begin
        if (data_addr_ok) m_pend = 0;
      end else if (acc) begin
        m_occ = 1; m_pend = bus;
      end else if (m_occ && WB_allowin_w_i) begin
        m_occ = 0;
      end
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have ports (name direction width meaning); clock and reset first:
- clk  in  1  sole clock, all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- EXE_valid_w_i  in  1  EXE holds a valid instruction.
- MEM_allowin_w_o  out  1  stage can accept from EXE this cycle.
- WB_allowin_w_i  in  1  WB can accept this cycle.
- MEM_valid_w_o  out  1  stage holds a completed instruction for WB.
- flush_w_i  in  1  exception/eret flush; kills stage contents.
- EXE_memReq_i, EXE_memWrite_i  in  1 each  load/store present; 1=store.
- EXE_memSize_i  in  2  0 byte, 1 half, 2 word.
- EXE_memAddr_i, EXE_rtData_i, EXE_VAddr_i, EXE_finalRes_i  in  32 each  address, store data/old rt, PC, ALU result.
- EXE_writeNum_i  in  `GPR_NUM; EXE_loadSel_i  in  `LOAD_SEL; EXE_exceptionRisk_i, EXE_isDangerous_i  in  1.
- MEM_writeNum_i ... MEM_loadSel_i  out  same widths as the WB inputs of the same names, plus MEM_alignCheck_i (2 bits, addr[1:0]); all registered.
- data_req, data_wr  out  1; data_size  out  2; data_addr, data_wdata  out  32; data_wstrb  out  4; data_addr_ok  in  1.

Function
REQ-002 SHALL latch all EXE_* fields when EXE_valid_w_i && MEM_allowin_w_o; otherwise hold.
REQ-003 SHALL run FSM per instruction: EMPTY, REQ (bus request pending), DONE (complete, awaiting WB).
REQ-004 EMPTY -> REQ on accept with memReq=1 and exceptionRisk=0; EMPTY -> DONE on accept otherwise.
REQ-005 In REQ, data_req SHALL be 1; REQ -> DONE on the edge where data_addr_ok=1.
REQ-006 DONE -> next state per REQ-004 when WB_allowin_w_i and EXE_valid_w_i; DONE -> EMPTY when WB_allowin_w_i and no EXE input.
REQ-007 MEM_valid_w_o SHALL be (state==DONE); MEM_allowin_w_o SHALL be (state==EMPTY) || (state==DONE && WB_allowin_w_i).
REQ-008 Bus data SHALL return the cycle after addr_ok and hold until the next accepted request; WB samples it the cycle after MEM hands over.
REQ-009 data_addr SHALL be {addr[31:2],2'b00} for stores and word-aligned data_size=2 for all loads.
REQ-010 Store wstrb/wdata: SB -> 4'b0001<<addr[1:0], byte replicated x4; SH -> 4'b0011<<addr[1:0], half replicated x2; SW -> 4'b1111, rtData.
REQ-011 data_req, data_wr, data_addr, data_wstrb, data_wdata SHALL be stable while REQ persists.
REQ-012 flush_w_i SHALL force state EMPTY next edge; if addr_ok coincides, the request counts as accepted but the instruction is discarded (MEM_valid_w_o=0).
REQ-013 Simultaneous flush and EXE_valid_w_i SHALL accept nothing.
REQ-014 MEM_alignCheck_i SHALL equal latched addr[1:0].

Reset
REQ-015 rst=0 SHALL asynchronously force state EMPTY, data_req=0, MEM_valid_w_o=0, all registered outputs 0; mid-request reset abandons the request.

Configuration
REQ-016 Macro MEM_UNALIGNED_LS_EN defined: SWL/SWR generate wstrb {1111>>(3-a), 1111<<a} with shifted rtData, loadSel L0-L2/R1-R3 passed through. Undefined: those loadSel bits and SWL/SWR forced to no-op (wstrb 0, no data_req).

Structure
REQ-017 FSM state encoding and size codes SHALL live in the shared MyDefines.v header; `LOAD_SEL bit indices reused.
REQ-018 Store strobe/data generation SHALL be a combinational sub-module store_align.

Verification
REQ-019 Reset mid-REQ with addr 0x100 -> data_req=0 within same cycle, state EMPTY.
REQ-020 SB addr 0x1003, rt 0x000000AB -> wstrb 4'b1000, wdata 0xABABABAB, data_addr 0x1000.
REQ-021 LW with addr_ok delayed 3 cycles -> MEM_allowin_w_o=0 for 3 cycles, MEM_valid_w_o=1 on cycle 4.
REQ-022 DONE with WB_allowin_w_i=0 for 2 cycles -> outputs held, no new data_req.
REQ-023 flush coincident with addr_ok -> MEM_valid_w_o=0 next cycle, EXE not accepted.
REQ-024 Non-memory ALU op back-to-back x4 -> one instruction/cycle, data_req never asserted.
